// File: rtl/tdc_readout.sv
// -----------------------------------------------------------------------------
// tdc_readout
//
// Consumer side of the TDC. Watches the synchronous `hit` line, pairs each
// rising edge with the following falling edge into one event, computes the
// pulse width in fine-bin units from the TDC's coarse counter and fine codes,
// and packs it with the start timestamp into a 19-bit word. Words go into a
// small first-word-fall-through FIFO that drains over a valid/ready stream.
//
// Ports
//   clk         in   1   system clock, shared with the TDC
//   rst         in   1   synchronous, active-high reset
//   hit         in   1   hit line, already synchronous to clk
//   bin_start   in   5   TDC fine code latched at hit rise
//   bin_stop    in   5   TDC fine code latched at hit fall
//   coarse      in   4   TDC coarse counter, wraps mod 16
//   out_data    out  19  {ovf, width[8:0], coarse_start[3:0], bin_start[4:0]}
//   out_valid   out  1   out_data holds a valid word
//   out_ready   in   1   consumer accepts the word when high with out_valid
//   drop_count  out  8   events lost to a full FIFO, saturates at 255
//   busy        out  1   high while an event is open
// -----------------------------------------------------------------------------
module tdc_readout #(
    parameter int FIFO_DEPTH = 8,   // power of two, >= 2
    parameter int NBINS      = 32   // fine bins per clock period
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic [4:0]  bin_start,
    input  logic [4:0]  bin_stop,
    input  logic [3:0]  coarse,
    output logic [18:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  drop_count,
    output logic        busy
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [9:0]      BINS_C   = 10'(NBINS);
    localparam logic [4:0]      DUR_SAT  = 5'd16;
    localparam logic [8:0]      WIDTH_MAX = 9'd511;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        PUSH = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Edge detection and event FSM
    // -------------------------------------------------------------------------
    state_t      state;
    logic        hit_q;
    logic [3:0]  cs;     // coarse at start
    logic [4:0]  bs;     // fine code at start
    logic [3:0]  ce;     // coarse at stop
    logic [4:0]  be;     // fine code at stop
    logic [4:0]  dur;    // cycles spent open, saturating at 16

    logic rise;
    logic fall;

    assign rise = hit & ~hit_q;
    assign fall = ~hit & hit_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            // Loading hit_q from hit means a hit already high when reset
            // releases is not mistaken for a fresh rising edge.
            hit_q <= hit;
            busy  <= 1'b0;
            cs    <= '0;
            bs    <= '0;
            ce    <= '0;
            be    <= '0;
            dur   <= '0;
        end else begin
            hit_q <= hit;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cs    <= coarse;
                        bs    <= bin_start;
                        dur   <= '0;
                        busy  <= 1'b1;
                        state <= OPEN;
                    end
                end

                OPEN: begin
                    // Counting includes the fall cycle, so dur ends up equal
                    // to the number of cycles hit was high (capped at 16).
                    if (dur != DUR_SAT) begin
                        dur <= dur + 5'd1;
                    end
                    if (fall) begin
                        ce    <= coarse;
                        be    <= bin_stop;
                        busy  <= 1'b0;
                        state <= PUSH;
                    end
                end

                PUSH: begin
                    // The word for the finished event is built from the
                    // current register values this cycle, so a new start can
                    // overwrite cs/bs/dur at the same edge without loss.
                    if (rise) begin
                        cs    <= coarse;
                        bs    <= bin_start;
                        dur   <= '0;
                        busy  <= 1'b1;
                        state <= OPEN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Width arithmetic and word packing
    // -------------------------------------------------------------------------
    logic [3:0]  dc;
    logic [9:0]  width_raw;   // interpreted as 10-bit two's complement
    logic [8:0]  width;
    logic        ovf;
    logic [18:0] word;

    // NOTE: every variable gets a value on every path through this block, so
    // no storage (latch) is inferred.
    always_comb begin
        dc  = ce - cs;                     // modulo-16 coarse distance
        ovf = (dur == DUR_SAT);
        // Range is -31 .. 511, which fits 10-bit signed; the modulo-1024
        // result of the unsigned sum is the correct two's complement value.
        width_raw = {6'b0, dc} * BINS_C + {5'b0, bs} - {5'b0, be};
        if (ovf) begin
            width = WIDTH_MAX;
        end else if (width_raw[9]) begin
            width = '0;                    // negative: stop fine code ran past
        end else begin
            width = width_raw[8:0];        // non-negative values never exceed 511
        end
        word = {ovf, width, cs, bs};
    end

    // -------------------------------------------------------------------------
    // First-word-fall-through FIFO
    // -------------------------------------------------------------------------
    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;

    assign full     = (count == DEPTH_C);
    assign push_req = (state == PUSH);
    assign pop      = out_valid & out_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & ~push_ok;

    // NOTE: the storage array has no reset; its contents are only observable
    // through count, which is reset, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign out_valid = (count != '0);
    // Head word is shown directly; it cannot change until it is popped, so it
    // holds while the consumer stalls. Zero when empty.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_tdc_readout.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout
//
// Self-checking bench for tdc_readout. A transaction-level reference model
// follows the hit waveform the bench drives, turns each rise/fall pair into
// the expected event word and queues it (or counts a drop) according to its
// own FIFO occupancy. A separate monitor compares the DUT stream, busy and
// drop_count against the model on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_tdc_readout;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit;
    logic [4:0]  bin_start;
    logic [4:0]  bin_stop;
    logic [3:0]  coarse;
    logic [18:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  drop_count;
    logic        busy;

    tdc_readout #(
        .FIFO_DEPTH (DEPTH),
        .NBINS      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hit        (hit),
        .bin_start  (bin_start),
        .bin_stop   (bin_stop),
        .coarse     (coarse),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit mon_en     = 1'b0;
    bit rand_ready = 1'b0;
    int ready_pct  = 100;

    // Reference model state
    logic [18:0] exp_q [$];
    int          m_occ      = 0;
    int          m_drops    = 0;
    int          m_cyc      = 0;
    int          m_rise_cyc = 0;
    int          m_cs       = 0;
    int          m_bs       = 0;
    bit          m_open     = 1'b0;
    bit          m_pend     = 1'b0;
    bit          m_prev_hit = 1'b0;
    logic [18:0] m_pend_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Event word from the arithmetic rules: modulo-16 coarse distance times
    // 32 plus fine start minus fine stop, clamped to 0..511; 16 or more high
    // cycles is an overflow with width 511.
    function automatic logic [18:0] event_word(int cs, int bs, int ce, int be, int high);
        int dc;
        int w;
        bit ovf;
        dc  = (ce - cs + 16) % 16;
        w   = dc * 32 + bs - be;
        ovf = (high >= 16);
        if (w < 0)   w = 0;
        if (w > 511) w = 511;
        if (ovf)     w = 511;
        return {ovf, w[8:0], cs[3:0], bs[4:0]};
    endfunction

    // Model: at each rising edge, consume the inputs of the cycle just ending.
    always @(posedge clk) begin
        bit pop;
        if (rst) begin
            m_open     = 1'b0;
            m_pend     = 1'b0;
            m_occ      = 0;
            m_drops    = 0;
            m_prev_hit = hit;
            exp_q.delete();
        end else begin
            pop = (m_occ > 0) && out_ready;
            // Word from a fall in the previous cycle is offered this cycle.
            if (m_pend) begin
                if ((m_occ < DEPTH) || pop) begin
                    exp_q.push_back(m_pend_word);
                    m_occ++;
                end else if (m_drops < 255) begin
                    m_drops++;
                end
                m_pend = 1'b0;
            end
            if (pop) m_occ--;
            if (!hit && m_prev_hit && m_open) begin
                m_pend_word = event_word(m_cs, m_bs, int'(coarse), int'(bin_stop),
                                         m_cyc - m_rise_cyc);
                m_pend = 1'b1;
                m_open = 1'b0;
            end
            if (hit && !m_prev_hit) begin
                m_open     = 1'b1;
                m_cs       = int'(coarse);
                m_bs       = int'(bin_start);
                m_rise_cyc = m_cyc;
            end
            m_prev_hit = hit;
        end
        m_cyc++;
    end

    // Monitor: compare DUT outputs in the middle of each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_occ != 0));
            check("busy", 32'(busy), 32'(m_open));
            check("drop_count", 32'(drop_count), 32'(m_drops));
            if (out_valid && (exp_q.size() != 0)) begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Advance to just after the next rising edge; fine/coarse inputs carry
    // noise whenever no edge needs them.
    task automatic step();
        @(posedge clk);
        #1;
        coarse    = 4'($urandom_range(0, 15));
        bin_start = 5'($urandom_range(0, 31));
        bin_stop  = 5'($urandom_range(0, 31));
        if (rand_ready) out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    // Hit high for `high` cycles; returns with the fall-cycle inputs applied.
    task automatic pulse(input int cs, input int bs, input int ce, input int be, input int high);
        step();
        hit       = 1'b1;
        coarse    = 4'(cs);
        bin_start = 5'(bs);
        repeat (high - 1) begin
            step();
            hit = 1'b1;
        end
        step();
        hit      = 1'b0;
        coarse   = 4'(ce);
        bin_stop = 5'(be);
    endtask

    // Called right after pulse(): the word must appear two cycles after the
    // fall-detection cycle with the given value.
    task automatic expect_word(input string name, input logic [18:0] exp);
        int lat;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'd2);
        if (lat >= 0) check({name, "_word"}, 32'(out_data), 32'(exp));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int gap;
        int high;

        rst       = 1'b1;
        hit       = 1'b0;
        out_ready = 1'b0;
        coarse    = '0;
        bin_start = '0;
        bin_stop  = '0;
        repeat (3) step();
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop_count", 32'(drop_count), 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();

        // Basic event
        pulse(3, 10, 7, 4, 5);
        expect_word("basic", {1'b0, 9'd134, 4'd3, 5'd10});
        repeat (3) step();

        // Coarse wrap 14 -> 2
        pulse(14, 0, 2, 0, 4);
        expect_word("wrap", {1'b0, 9'd128, 4'd14, 5'd0});
        repeat (3) step();

        // Long pulse overflows
        pulse(5, 7, 9, 1, 20);
        expect_word("long", {1'b1, 9'd511, 4'd5, 5'd7});
        repeat (3) step();

        // Fifteen high cycles stays below overflow
        pulse(1, 2, 3, 2, 15);
        expect_word("just_short", {1'b0, 9'd64, 4'd1, 5'd2});
        repeat (3) step();

        // Negative width clamps to zero
        pulse(6, 3, 6, 9, 3);
        expect_word("neg_clamp", {1'b0, 9'd0, 4'd6, 5'd3});
        repeat (3) step();

        // FIFO full: nine events into a stalled FIFO of eight
        out_ready = 1'b0;
        for (int e = 0; e < 9; e++) begin
            pulse(e, e + 1, e + 2, 0, 2);
            step();
            hit = 1'b0;
        end
        repeat (3) step();
        @(negedge clk);
        check("full_drop_count", 32'(drop_count), 32'd1);
        step();
        out_ready = 1'b1;
        run = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid && (run == k)) run++;
        end
        check("full_drain_run", 32'(run), 32'd8);
        check("full_drained_valid", 32'(out_valid), 32'd0);

        // Reset while an event is open
        step();
        hit = 1'b1;
        step();
        hit = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        hit = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_drop_count", 32'(drop_count), 32'd0);

        // Randomized events with back-to-back starts and random back-pressure
        rand_ready = 1'b1;
        for (int e = 0; e < 150; e++) begin
            case (e % 3)
                0:       ready_pct = 90;
                1:       ready_pct = 30;
                default: ready_pct = 5;
            endcase
            high = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
            pulse($urandom_range(0, 15), $urandom_range(0, 31),
                  $urandom_range(0, 15), $urandom_range(0, 31), high);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                step();
                hit = 1'b0;
            end
        end

        // Drain everything that is left
        rand_ready = 1'b0;
        step();
        hit       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((m_occ == 0) && !m_pend) break;
        end
        @(negedge clk);
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
